// File: rtl/lsu_mem_access.sv
// lsu_mem_access: MEM-stage load/store unit.
// Issues a single data-bus request per load/store, sizes and positions store
// data with byte enables, formats load data (sign/zero extension) into a
// registered lData, flags misaligned accesses and holds the pipeline in stall
// until the bus acknowledges or the request times out.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   memRen, memWen   MEM-stage load / store strobes (both set = store)
//   funct3           access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr, sData      effective byte address, store source data
//   busReq/busWe/busAddr/busWData/busBe   data-bus request (held during REQ)
//   busAck, busRData single-cycle completion and read word
//   lData            formatted load result (registered)
//   stall            freeze upstream pipeline registers (combinational)
//   misalign         misaligned access flag (combinational)
//   accessFault      one-cycle pulse after a bus timeout
module lsu_mem_access #(
  parameter int unsigned BITWIDTH       = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                memRen,
  input  logic                memWen,
  input  logic [2:0]          funct3,
  input  logic [BITWIDTH-1:0] addr,
  input  logic [BITWIDTH-1:0] sData,
  output logic                busReq,
  output logic                busWe,
  output logic [BITWIDTH-1:0] busAddr,
  output logic [BITWIDTH-1:0] busWData,
  output logic [3:0]          busBe,
  input  logic                busAck,
  input  logic [BITWIDTH-1:0] busRData,
  output logic [BITWIDTH-1:0] lData,
  output logic                stall,
  output logic                misalign,
  output logic                accessFault
);

  localparam int unsigned DW    = BITWIDTH;
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       f3_q, f3_nxt;
  logic [1:0]       off_q, off_nxt;
  logic [DW-1:0]    addr_q, addr_nxt;
  logic [DW-1:0]    wdata_q, wdata_nxt;
  logic [3:0]       be_q, be_nxt;
  logic             we_q, we_nxt;
  logic [DW-1:0]    ldata_q, ldata_nxt;
  logic             fault_q, fault_nxt;

  // Size decode: undefined encodings (011, 110, 111) fall through to word.
  logic access_c;
  logic size_b_c;
  logic size_h_c;
  logic size_w_c;
  logic misalign_c;
  logic go_c;

  always_comb begin
    access_c   = memRen | memWen;
    size_b_c   = (funct3[1:0] == 2'b00);
    size_h_c   = (funct3[1:0] == 2'b01);
    size_w_c   = ~size_b_c & ~size_h_c;
    misalign_c = access_c & ((size_h_c & addr[0]) | (size_w_c & (addr[1:0] != 2'b00)));
  end

  // Misalignment is only meaningful while a new access can be accepted.
  assign misalign = ~rst & (state == IDLE) & misalign_c;
  assign go_c     = ~rst & access_c & ~misalign;

  // DONE deliberately releases stall so the pipeline advances past this instr.
  assign stall = ~rst & (((state == IDLE) & go_c) | (state == REQ));

  // Store lane positioning and byte enables; loads always read the full word.
  logic [DW-1:0] st_wdata_c;
  logic [3:0]    st_be_c;

  always_comb begin
    st_wdata_c = sData;
    st_be_c    = 4'b1111;
    if (memWen) begin
      if (size_b_c) begin
        st_wdata_c = {4{sData[7:0]}};
        st_be_c    = 4'b0001 << addr[1:0];
      end else if (size_h_c) begin
        st_wdata_c = {2{sData[15:0]}};
        st_be_c    = addr[1] ? 4'b1100 : 4'b0011;
      end
    end
  end

  // Extract and extend the addressed byte/half from the returned word.
  function automatic logic [DW-1:0] fmt_load(input logic [DW-1:0] rd,
                                             input logic [2:0]    f3,
                                             input logic [1:0]    off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [DW-1:0] res;
    case (off)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = off[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b100:  res = {24'd0, b};
      3'b101:  res = {16'd0, h};
      default: res = rd;
    endcase
    return res;
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      ldata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      f3_q    <= f3_nxt;
      off_q   <= off_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      be_q    <= be_nxt;
      we_q    <= we_nxt;
      ldata_q <= ldata_nxt;
      fault_q <= fault_nxt;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    f3_nxt    = f3_q;
    off_nxt   = off_q;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    be_nxt    = be_q;
    we_nxt    = we_q;
    ldata_nxt = ldata_q;
    fault_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (go_c) begin
          addr_nxt  = {addr[DW-1:2], 2'b00};
          we_nxt    = memWen;
          be_nxt    = st_be_c;
          wdata_nxt = st_wdata_c;
          f3_nxt    = funct3;
          off_nxt   = addr[1:0];
          cnt_nxt   = '0;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (busAck) begin
          if (!we_q) ldata_nxt = fmt_load(busRData, f3_q, off_q);
          state_nxt = DONE;
        end else if (cnt == CNT_LAST) begin
          if (!we_q) ldata_nxt = '0;
          fault_nxt = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busReq      = (state == REQ);
  assign busWe       = we_q;
  assign busAddr     = addr_q;
  assign busWData    = wdata_q;
  assign busBe       = be_q;
  assign lData       = ldata_q;
  assign accessFault = fault_q;

endmodule

// File: tb/tb_lsu_mem_access.sv
// Directed bench for lsu_mem_access: a default-timeout instance for the
// functional cases and a TIMEOUT_CYCLES=4 instance for the fault path.
module tb_lsu_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        memRen, memWen, busAck;
  logic [2:0]  funct3;
  logic [31:0] addr, sData, busRData;
  logic        busReq, busWe, stall, misalign, accessFault;
  logic [31:0] busAddr, busWData, lData;
  logic [3:0]  busBe;

  logic        t_ren, t_wen, t_ack;
  logic [2:0]  t_f3;
  logic [31:0] t_addr, t_sdata, t_rdata;
  logic        t_busReq, t_busWe, t_stall, t_misalign, t_fault;
  logic [31:0] t_busAddr, t_busWData, t_lData;
  logic [3:0]  t_busBe;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lsu_mem_access dut (
    .clk(clk), .rst(rst), .memRen(memRen), .memWen(memWen), .funct3(funct3),
    .addr(addr), .sData(sData), .busReq(busReq), .busWe(busWe),
    .busAddr(busAddr), .busWData(busWData), .busBe(busBe), .busAck(busAck),
    .busRData(busRData), .lData(lData), .stall(stall), .misalign(misalign),
    .accessFault(accessFault)
  );

  lsu_mem_access #(.BITWIDTH(32), .TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .rst(rst), .memRen(t_ren), .memWen(t_wen), .funct3(t_f3),
    .addr(t_addr), .sData(t_sdata), .busReq(t_busReq), .busWe(t_busWe),
    .busAddr(t_busAddr), .busWData(t_busWData), .busBe(t_busBe), .busAck(t_ack),
    .busRData(t_rdata), .lData(t_lData), .stall(t_stall), .misalign(t_misalign),
    .accessFault(t_fault)
  );

  // Drives one MEM-stage instruction on the main instance until stall drops,
  // acking on REQ cycle ack_at (0 = never) and recording what was observed.
  task automatic run_access(input logic ren, input logic wen, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] sd,
                            input int ack_at, input logic [31:0] rd,
                            output int n_stall, output int n_req, output int n_fault,
                            output logic mis0, output logic [31:0] c_addr,
                            output logic [31:0] c_wdata, output logic [3:0] c_be,
                            output logic c_we);
    bit done;
    memRen = ren; memWen = wen; funct3 = f3; addr = a; sData = sd;
    busAck = 1'b0; busRData = rd;
    n_stall = 0; n_req = 0; n_fault = 0; done = 0;
    c_addr = '0; c_wdata = '0; c_be = '0; c_we = 1'b0;
    #1;
    mis0 = misalign;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      if (busReq) begin
        n_req++;
        c_addr = busAddr; c_wdata = busWData; c_be = busBe; c_we = busWe;
        busAck = (n_req == ack_at);
      end else begin
        busAck = 1'b0;
      end
      if (accessFault) n_fault++;
      if (stall) n_stall++;
      else done = 1;
      if (!done) begin
        @(posedge clk); #1;
      end
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL access_bound: stall never dropped within 300 cycles (addr %h)", a);
    end
    memRen = 1'b0; memWen = 1'b0; busAck = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    memRen = 1'b1; memWen = 1'b0; funct3 = 3'b010; addr = 32'h1; sData = '0;
    busAck = 1'b0; busRData = '0;
    t_ren = 1'b0; t_wen = 1'b0; t_f3 = 3'b010; t_addr = '0; t_sdata = '0;
    t_ack = 1'b0; t_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (stall !== 1'b0 || misalign !== 1'b0) begin
      n_fail++; $display("FAIL reset_comb: stall=%b misalign=%b, want 0 0", stall, misalign);
    end
    n_checks++;
    if (busReq !== 1'b0 || busWe !== 1'b0 || busAddr !== 32'h0 || busWData !== 32'h0 ||
        busBe !== 4'h0 || lData !== 32'h0 || accessFault !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_regs: req=%b we=%b addr=%h wd=%h be=%h ld=%h flt=%b, want all 0",
               busReq, busWe, busAddr, busWData, busBe, lData, accessFault);
    end
    memRen = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_load_byte();
    int ns, nr, nf; logic m; logic [31:0] ca, cw; logic [3:0] cb; logic cwe;
    run_access(1, 0, 3'b000, 32'h1003, 32'h0, 1, 32'h80FF_1234, ns, nr, nf, m, ca, cw, cb, cwe);
    n_checks++;
    if (ca !== 32'h1000 || cb !== 4'b1111 || cwe !== 1'b0) begin
      n_fail++; $display("FAIL lb_bus: addr=%h be=%b we=%b, want 00001000 1111 0", ca, cb, cwe);
    end
    n_checks++;
    if (ns !== 2 || nr !== 1) begin
      n_fail++; $display("FAIL lb_latency: stall=%0d req=%0d, want 2 1", ns, nr);
    end
    n_checks++;
    if (lData !== 32'hFFFF_FF80) begin
      n_fail++; $display("FAIL lb_data: lData=%h, want ffffff80", lData);
    end
    run_access(1, 0, 3'b100, 32'h1003, 32'h0, 1, 32'h80FF_1234, ns, nr, nf, m, ca, cw, cb, cwe);
    n_checks++;
    if (lData !== 32'h0000_0080) begin
      n_fail++; $display("FAIL lbu_data: lData=%h, want 00000080", lData);
    end
  endtask

  task automatic test_stores();
    int ns, nr, nf; logic m; logic [31:0] ca, cw; logic [3:0] cb; logic cwe;
    run_access(0, 1, 3'b001, 32'h2002, 32'hDEAD_BEEF, 1, 32'h0, ns, nr, nf, m, ca, cw, cb, cwe);
    n_checks++;
    if (cwe !== 1'b1 || cb !== 4'b1100 || cw !== 32'hBEEF_BEEF || ca !== 32'h2000) begin
      n_fail++; $display("FAIL sh_bus: we=%b be=%b wd=%h addr=%h, want 1 1100 beefbeef 00002000",
                         cwe, cb, cw, ca);
    end
    n_checks++;
    if (lData !== 32'h0000_0080) begin
      n_fail++; $display("FAIL sh_ldata: lData=%h, want 00000080 (unchanged)", lData);
    end
    run_access(0, 1, 3'b000, 32'h4001, 32'h1234_56A5, 1, 32'h0, ns, nr, nf, m, ca, cw, cb, cwe);
    n_checks++;
    if (cb !== 4'b0010 || cw !== 32'hA5A5_A5A5 || ca !== 32'h4000) begin
      n_fail++; $display("FAIL sb_bus: be=%b wd=%h addr=%h, want 0010 a5a5a5a5 00004000", cb, cw, ca);
    end
  endtask

  task automatic test_misalign();
    int ns, nr, nf; logic m; logic [31:0] ca, cw; logic [3:0] cb; logic cwe;
    run_access(1, 0, 3'b010, 32'h3001, 32'h0, 1, 32'h0, ns, nr, nf, m, ca, cw, cb, cwe);
    n_checks++;
    if (m !== 1'b1 || ns !== 0 || nr !== 0) begin
      n_fail++; $display("FAIL lw_misalign: mis=%b stall=%0d req=%0d, want 1 0 0", m, ns, nr);
    end
    n_checks++;
    if (busReq !== 1'b0) begin
      n_fail++; $display("FAIL lw_misalign_req: busReq=%b, want 0", busReq);
    end
    run_access(1, 0, 3'b011, 32'h5002, 32'h0, 1, 32'h0, ns, nr, nf, m, ca, cw, cb, cwe);
    n_checks++;
    if (m !== 1'b1 || nr !== 0) begin
      n_fail++; $display("FAIL undef_f3_misalign: mis=%b req=%0d, want 1 0", m, nr);
    end
    run_access(1, 0, 3'b001, 32'h3002, 32'h0, 1, 32'h8001_7FFF, ns, nr, nf, m, ca, cw, cb, cwe);
    n_checks++;
    if (m !== 1'b0 || ns !== 2 || lData !== 32'hFFFF_8001) begin
      n_fail++; $display("FAIL lh_upper: mis=%b stall=%0d lData=%h, want 0 2 ffff8001", m, ns, lData);
    end
    run_access(1, 0, 3'b101, 32'h0000, 32'h0, 1, 32'h1234_F00D, ns, nr, nf, m, ca, cw, cb, cwe);
    n_checks++;
    if (lData !== 32'h0000_F00D) begin
      n_fail++; $display("FAIL lhu_lower: lData=%h, want 0000f00d", lData);
    end
  endtask

  task automatic test_delayed_ack();
    int ns, nr, nf; logic m; logic [31:0] ca, cw; logic [3:0] cb; logic cwe;
    run_access(1, 0, 3'b010, 32'h7004, 32'h0, 5, 32'h1234_5678, ns, nr, nf, m, ca, cw, cb, cwe);
    n_checks++;
    if (ns !== 6 || nr !== 5 || nf !== 0) begin
      n_fail++; $display("FAIL lw_delayed: stall=%0d req=%0d fault=%0d, want 6 5 0", ns, nr, nf);
    end
    n_checks++;
    if (lData !== 32'h1234_5678) begin
      n_fail++; $display("FAIL lw_delayed_data: lData=%h, want 12345678", lData);
    end
    // Both strobes set: treated as a store, lData untouched.
    run_access(1, 1, 3'b010, 32'h8000, 32'h55AA_55AA, 1, 32'hFFFF_FFFF, ns, nr, nf, m, ca, cw, cb, cwe);
    n_checks++;
    if (cwe !== 1'b1 || cb !== 4'b1111 || cw !== 32'h55AA_55AA || lData !== 32'h1234_5678) begin
      n_fail++; $display("FAIL both_strobes: we=%b be=%b wd=%h lData=%h, want 1 1111 55aa55aa 12345678",
                         cwe, cb, cw, lData);
    end
  endtask

  task automatic test_timeout();
    int nr, nf, ns;
    bit done;
    // Successful load first so the fault path visibly clears lData.
    t_ren = 1'b1; t_f3 = 3'b010; t_addr = 32'h6000; t_rdata = 32'hCAFE_F00D; t_ack = 1'b0;
    done = 0;
    #1;
    for (int cyc = 0; cyc < 50 && !done; cyc++) begin
      t_ack = t_busReq;
      if (!t_stall) done = 1;
      else begin @(posedge clk); #1; end
    end
    t_ren = 1'b0; t_ack = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (t_lData !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL to_preload: lData=%h, want cafef00d", t_lData);
    end
    t_ren = 1'b1; t_addr = 32'h6004;
    nr = 0; nf = 0; ns = 0; done = 0;
    #1;
    for (int cyc = 0; cyc < 50 && !done; cyc++) begin
      if (t_busReq) nr++;
      if (t_fault) nf++;
      if (t_stall) ns++;
      else done = 1;
      if (!done) begin @(posedge clk); #1; end
    end
    n_checks++;
    if (!done || nr !== 4 || nf !== 1 || ns !== 5) begin
      n_fail++; $display("FAIL timeout_seq: done=%0d req=%0d fault=%0d stall=%0d, want 1 4 1 5",
                         done, nr, nf, ns);
    end
    n_checks++;
    if (t_lData !== 32'h0) begin
      n_fail++; $display("FAIL timeout_ldata: lData=%h, want 00000000", t_lData);
    end
    t_ren = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (t_fault !== 1'b0 || t_busReq !== 1'b0 || t_stall !== 1'b0) begin
      n_fail++; $display("FAIL timeout_idle: fault=%b req=%b stall=%b, want 0 0 0",
                         t_fault, t_busReq, t_stall);
    end
  endtask

  task automatic test_reset_in_req();
    memRen = 1'b1; memWen = 1'b0; funct3 = 3'b010; addr = 32'h9000; busAck = 1'b0;
    busRData = 32'hA5A5_0000;
    @(posedge clk); #1;
    n_checks++;
    if (busReq !== 1'b1) begin
      n_fail++; $display("FAIL rreq_enter: busReq=%b, want 1", busReq);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busReq !== 1'b0 || stall !== 1'b0 || lData !== 32'h0) begin
      n_fail++; $display("FAIL rreq_reset: busReq=%b stall=%b lData=%h, want 0 0 00000000",
                         busReq, stall, lData);
    end
    memRen = 1'b0;
    rst = 1'b0;
    busAck = 1'b1;
    @(posedge clk); #1;
    busAck = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (busReq !== 1'b0 || lData !== 32'h0 || accessFault !== 1'b0) begin
      n_fail++; $display("FAIL rreq_late_ack: busReq=%b lData=%h fault=%b, want 0 00000000 0",
                         busReq, lData, accessFault);
    end
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_stores();
    test_misalign();
    test_delayed_ack();
    test_timeout();
    test_reset_in_req();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_access.md
Name: lsu_mem_access

Overview:
- Load/store unit in the MEM stage. It drives the data-bus request for load and store instructions and formats load data onto lData, which feeds the MEM/WB pipeline register.
- Handles byte/half/word sizing, byte enables, sign/zero extension and misalignment detection.
- Stalls the pipeline until the bus acknowledges or the access times out.

Parameters:
- BITWIDTH, 32, data/address width (fixed 32; other values unsupported)
- TIMEOUT_CYCLES, 255, max cycles in REQ without busAck before fault (1..65535)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- memRen  in  1  current MEM-stage instr is a load
- memWen  in  1  current MEM-stage instr is a store
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  effective byte address
- sData  in  32  store source data (rs2)
- busReq  out  1  bus request valid
- busWe  out  1  1 = write
- busAddr  out  32  word-aligned address (addr[1:0] forced 0)
- busWData  out  32  lane-positioned write data
- busBe  out  4  byte enables
- busAck  in  1  bus completion, single-cycle pulse
- busRData  in  32  read word, valid with busAck
- lData  out  32  formatted load result, registered
- stall  out  1  freeze IF/ID/EX/MEM registers
- misalign  out  1  misaligned access flag, combinational
- accessFault  out  1  one-cycle pulse on timeout

Behaviour:
- Reset values: state IDLE; busReq 0, busWe 0, busAddr 0, busWData 0, busBe 0, lData 0, accessFault 0, timeout counter 0. While rst=1, stall=0 and misalign=0.
- go = (memRen | memWen) & ~misalign.
- misalign = (memRen | memWen) & ((size H & addr[0]) | (size W & addr[1:0]!=0)). Evaluated only in IDLE; 0 in other states.
- Undefined funct3 (011, 110, 111) is treated as a word access (W, no sign handling).
- If memRen and memWen are both 1, the access is a store.
- FSM states: IDLE, REQ, DONE.
  - IDLE: if go, register busAddr/busWe/busBe/busWData/funct3/addr[1:0], clear counter, go to REQ. Otherwise stay in IDLE. A misaligned access issues no request and does not stall.
  - REQ: busReq=1, all bus outputs held stable.
    - busAck: for a load, lData <= formatted busRData; go to DONE.
    - No busAck and counter == TIMEOUT_CYCLES-1: lData <= 0 for a load (store: lData unchanged), accessFault <= 1, go to DONE.
    - Otherwise counter++.
  - DONE: busReq=0, stall=0, accessFault cleared at the next edge. Go to IDLE unconditionally, so the same instruction never re-issues.
- stall = (IDLE & go) | REQ. It is 0 in DONE, so the pipeline advances at the end of DONE.
- busReq is decoded from the state register (glitch-free). busAck outside REQ is ignored.
- Store formatting:
  - SB: busBe = 0001 << addr[1:0]; busWData = {4{sData[7:0]}}.
  - SH: busBe = 0011 (addr[1]=0) or 1100; busWData = {2{sData[15:0]}}.
  - SW: busBe = 1111; busWData = sData.
- Load formatting:
  - Select byte at busRData[8*off +: 8] or half at busRData[16*addr[1] +: 16].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- Loads use busBe = 1111 and busWe = 0.
- lData holds its value between loads; stores never change lData.
- Minimum latency:
  - cycle 0: IDLE, stall=1
  - cycle 1: REQ, busAck
  - cycle 2: DONE, lData valid, stall=0
  - Total: 2 stall cycles.
- Reset in REQ: next edge gives IDLE, busReq=0, and the pending access is abandoned. A later busAck is ignored.

Test Plan:
- LB, addr=0x1003, busRData=0x80FF_1234, ack on first REQ cycle -> busAddr=0x1000, busBe=1111, stall high 2 cycles, lData=0xFFFF_FF80; LBU on the same data -> 0x0000_0080.
- SH, addr=0x2002, sData=0xDEAD_BEEF -> busWe=1, busBe=1100, busWData=0xBEEF_BEEF, lData unchanged.
- LW, addr=0x3001 -> misalign=1, busReq never asserts, stall=0; LH addr=0x3002 proceeds normally.
- LW with busAck delayed 5 cycles, busRData=0x1234_5678 -> stall=1 for 6 cycles, busReq high exactly 5 cycles, lData=0x1234_5678.
- TIMEOUT_CYCLES=4, no ack -> busReq high 4 cycles, accessFault pulses 1 cycle, lData=0, FSM back in IDLE.
- Reset asserted in REQ, then busAck pulsed -> busReq=0 after the edge, lData stays 0, no accessFault.
